video_timing_gen: RTL and testbench

//  Free-running output timing generator downstream of video_detect/video_judgement.

---
 rtl/video_timing_gen.sv | 259 +++++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running hsync/vsync/de generator for the output side.
// Timing numbers are latched only at frame boundaries; o_rd runs p_rd_lead cycles ahead of o_de.

module video_timing_gen #(
    parameter int p_cnt_width = 13,
    parameter int p_rd_lead   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_frm_gen_enable,
    input  logic [p_cnt_width-1:0] i_hs_total_num,
    input  logic [p_cnt_width-1:0] i_vs_total_num,
    input  logic [p_cnt_width-1:0] i_hsyn_num,
    input  logic [p_cnt_width-1:0] i_vsyn_num,
    input  logic [p_cnt_width-1:0] i_video_start_pixel,
    input  logic [p_cnt_width-1:0] i_video_end_pixel,
    input  logic [p_cnt_width-1:0] i_video_start_H,
    input  logic [p_cnt_width-1:0] i_video_end_H,
    output logic                   o_hsyn,
    output logic                   o_vsyn,
    output logic                   o_de,
    output logic                   o_rd,
    output logic                   o_frame_start,
    output logic                   o_param_err
);

    localparam int W = p_cnt_width;

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] H_MIN = W'(16);
    localparam logic [W-1:0] V_MIN = W'(4);

    // Bit positions inside the decoded strobe bundle.
    localparam int B_HS = 2;
    localparam int B_VS = 1;
    localparam int B_DE = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [W-1:0] h_tot;
        logic [W-1:0] v_tot;
        logic [W-1:0] hsyn;
        logic [W-1:0] vsyn;
        logic [W-1:0] sp;
        logic [W-1:0] ep;
        logic [W-1:0] sh;
        logic [W-1:0] eh;
    } timing_t;

    state_t       state_q;
    state_t       state_d;

    timing_t      cfg_in;
    timing_t      cfg_q;
    timing_t      cfg_d;

    logic [W-1:0] h_q;
    logic [W-1:0] h_d;
    logic [W-1:0] v_q;
    logic [W-1:0] v_d;

    logic         err_q;
    logic         err_d;

    logic [2:0]   tim_q;
    logic [2:0]   tim_d;

    logic [2:0]   tap;
    logic         vs_prev_q;

    logic         h_ok;
    logic         v_ok;
    logic         cfg_ok;
    logic         go;
    logic         h_last;
    logic         v_last;
    logic         frame_end;
    logic         latch;
    logic         run;

    assign cfg_in = '{
        h_tot: i_hs_total_num,
        v_tot: i_vs_total_num,
        hsyn:  i_hsyn_num,
        vsyn:  i_vsyn_num,
        sp:    i_video_start_pixel,
        ep:    i_video_end_pixel,
        sh:    i_video_start_H,
        eh:    i_video_end_H
    };

    // Check the incoming timing numbers before they may be latched.
    always_comb begin
        h_ok = (cfg_in.h_tot >= H_MIN)
            && (cfg_in.hsyn != '0)
            && (cfg_in.hsyn < cfg_in.sp)
            && (cfg_in.sp < cfg_in.ep)
            && (cfg_in.ep <= cfg_in.h_tot);
        v_ok = (cfg_in.v_tot >= V_MIN)
            && (cfg_in.vsyn != '0)
            && (cfg_in.vsyn < cfg_in.sh)
            && (cfg_in.sh < cfg_in.eh)
            && (cfg_in.eh <= cfg_in.v_tot);
        cfg_ok = h_ok && v_ok;
    end

    assign go        = i_frm_gen_enable && cfg_ok;
    assign run       = (state_q == S_RUN);
    assign h_last    = (h_q == cfg_q.h_tot - ONE);
    assign v_last    = (v_q == cfg_q.v_tot - ONE);
    assign frame_end = run && h_last && v_last;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave RUN only at the last cycle of a frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (frame_end && !go) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: latch strobe, error flag and raster counters.
    always_comb begin
        latch = 1'b0;
        err_d = err_q;
        h_d   = h_q;
        v_d   = v_q;
        unique case (state_q)
            S_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (i_frm_gen_enable) begin
                    latch = cfg_ok;
                    err_d = !cfg_ok;
                end
            end
            S_RUN: begin
                if (frame_end) begin
                    h_d = '0;
                    v_d = '0;
                    if (i_frm_gen_enable) begin
                        latch = cfg_ok;
                        err_d = !cfg_ok;
                    end
                end else if (h_last) begin
                    h_d = '0;
                    v_d = v_q + ONE;
                end else begin
                    h_d = h_q + ONE;
                end
            end
            default: begin
                h_d = '0;
                v_d = '0;
            end
        endcase
    end

    assign cfg_d = latch ? cfg_in : cfg_q;

    // Counters, latched timing and error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cfg_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            err_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            h_q   <= h_d;
            v_q   <= v_d;
            err_q <= err_d;
        end
    end

    // Raster decode from the latched numbers; forced low outside RUN.
    always_comb begin
        tim_d       = '0;
        tim_d[B_HS] = run && (h_q < cfg_q.hsyn);
        tim_d[B_VS] = run && (v_q < cfg_q.vsyn);
        tim_d[B_DE] = run
            && (h_q >= cfg_q.sp) && (h_q < cfg_q.ep)
            && (v_q >= cfg_q.sh) && (v_q < cfg_q.eh);
    end

    // Registered decode; its de bit is the early fetch strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tim_q <= '0;
        end else begin
            tim_q <= tim_d;
        end
    end

    generate
        if (p_rd_lead == 0) begin : g_nodly
            assign tap = tim_q;
        end else begin : g_dly
            logic [2:0] dly_q [p_rd_lead];

            // Shift the strobes so sync and de trail o_rd by the lead.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < p_rd_lead; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= tim_q;
                    for (int i = 1; i < p_rd_lead; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign tap = dly_q[p_rd_lead-1];
        end
    endgenerate

    // Remember the last output vsync to find its rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_prev_q <= 1'b0;
        end else begin
            vs_prev_q <= tap[B_VS];
        end
    end

    assign o_hsyn        = tap[B_HS];
    assign o_vsyn        = tap[B_VS];
    assign o_de          = tap[B_DE];
    assign o_rd          = tim_q[B_DE];
    assign o_frame_start = tap[B_VS] && !vs_prev_q;
    assign o_param_err   = err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: per-cycle point expectations and per-frame
// statistics are queued by the stimulus and checked by an independent monitor.

module tb_video_timing_gen;

    localparam int W    = 13;
    localparam int LEAD = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] ht, vt, hsn, vsn, sp, ep, sh, eh;
    logic         hsyn, vsyn, de, rd, fs, err;

    video_timing_gen #(
        .p_cnt_width (W),
        .p_rd_lead   (LEAD)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_frm_gen_enable    (en),
        .i_hs_total_num      (ht),
        .i_vs_total_num      (vt),
        .i_hsyn_num          (hsn),
        .i_vsyn_num          (vsn),
        .i_video_start_pixel (sp),
        .i_video_end_pixel   (ep),
        .i_video_start_H     (sh),
        .i_video_end_H       (eh),
        .o_hsyn              (hsyn),
        .o_vsyn              (vsyn),
        .o_de                (de),
        .o_rd                (rd),
        .o_frame_start       (fs),
        .o_param_err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int len;
        int de;
        int lines;
        int hs;
        int lerr;
    } frame_t;

    frame_t     fq[$];
    string      pname_q[$];
    logic [5:0] pexp_q[$];

    int flush_req = 0;
    int abort_req = 0;
    int done_req  = 0;
    int total     = 0;
    int passed    = 0;

    // Point expectation for the next negedge: {hs,vs,de,rd,fs,err}.
    task automatic expect_next(input string nm, input logic [5:0] ev);
        pname_q.push_back(nm);
        pexp_q.push_back(ev);
    endtask

    task automatic push_frame(input int len, input int d, input int l, input int h);
        frame_t f;
        f.len   = len;
        f.de    = d;
        f.lines = l;
        f.hs    = h;
        f.lerr  = 0;
        fq.push_back(f);
    endtask

    task automatic set_small();
        ht = 16; vt = 8; hsn = 2; vsn = 1;
        sp = 4; ep = 12; sh = 2; eh = 6;
    endtask

    task automatic wait_fs(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (fs === 1'b1) got = 1'b1;
        end
        if (!got) begin
            @(posedge clk);
            #1;
            expect_next(nm, 6'b000010);
        end
    endtask

    task automatic close_frame(input frame_t g);
        frame_t e;
        bit ok;
        total++;
        if (fq.size() == 0) begin
            $display("FAIL frame_unexpected: got len=%0d de=%0d lines=%0d hs=%0d, want no frame",
                     g.len, g.de, g.lines, g.hs);
        end else begin
            e  = fq.pop_front();
            ok = (g.de == e.de) && (g.lines == e.lines) && (g.hs == e.hs)
              && (g.lerr == e.lerr) && (e.len < 0 || g.len == e.len);
            if (ok) passed++;
            else $display("FAIL frame: got len=%0d de=%0d lines=%0d hs=%0d lead_err=%0d, want len=%0d de=%0d lines=%0d hs=%0d lead_err=%0d",
                          g.len, g.de, g.lines, g.hs, g.lerr, e.len, e.de, e.lines, e.hs, e.lerr);
        end
    endtask

    // Monitor: pops point expectations and accumulates per-frame statistics.
    initial begin : mon
        int     cyc;
        int     flush_seen;
        int     abort_seen;
        bit     in_frame;
        frame_t st;
        logic   prev_de, prev_hs;
        logic   rd_hist [LEAD];
        logic [5:0] act, ev;
        string  nm;
        cyc = 0; flush_seen = 0; abort_seen = 0; in_frame = 1'b0;
        st = '0; prev_de = 1'b0; prev_hs = 1'b0;
        for (int i = 0; i < LEAD; i++) rd_hist[i] = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            act = {hsyn, vsyn, de, rd, fs, err};
            if (pexp_q.size() != 0) begin
                nm = pname_q.pop_front();
                ev = pexp_q.pop_front();
                total++;
                if (act === ev) passed++;
                else $display("FAIL %s: got %b want %b (hs vs de rd fs err)", nm, act, ev);
            end
            if (abort_req != abort_seen) begin
                abort_seen = abort_req;
                in_frame   = 1'b0;
            end
            if (flush_req != flush_seen) begin
                flush_seen = flush_req;
                if (in_frame) close_frame(st);
                in_frame = 1'b0;
            end
            if (fs === 1'b1) begin
                if (in_frame) close_frame(st);
                in_frame = 1'b1;
                st       = '0;
                prev_de  = 1'b0;
                prev_hs  = 1'b0;
            end
            if (in_frame) begin
                st.len = st.len + 1;
                if (de === 1'b1) st.de = st.de + 1;
                if (de === 1'b1 && !prev_de) st.lines = st.lines + 1;
                if (hsyn === 1'b1 && !prev_hs) st.hs = st.hs + 1;
                if (de !== rd_hist[LEAD-1]) st.lerr = st.lerr + 1;
                prev_de = de;
                prev_hs = hsyn;
            end
            for (int i = LEAD - 1; i > 0; i--) rd_hist[i] = rd_hist[i-1];
            rd_hist[0] = rd;
            if (done_req != 0) begin
                total++;
                if (fq.size() == 0 && pexp_q.size() == 0) passed++;
                else $display("FAIL sb_drain: got %0d frames %0d points pending, want 0 0",
                              fq.size(), pexp_q.size());
                $display("%0d/%0d checks passed", passed, total);
                $finish;
            end
            if (cyc > 60000) begin
                total++;
                $display("FAIL watchdog: got %0d cycles, want completion", cyc);
                $display("%0d/%0d checks passed", passed, total);
                $finish;
            end
        end
    end

    // Stimulus.
    initial begin : stim
        rst = 1'b1;
        en  = 1'b0;
        set_small();
        ep  = 4;
        repeat (3) @(posedge clk);
        #1;
        expect_next("reset", 6'b000000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_next("idle_disabled", 6'b000000);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            expect_next("param_err", 6'b000001);
        end
        ep = 12;
        push_frame(128, 32, 4, 8);
        push_frame(128, 32, 4, 8);
        push_frame(128, 32, 4, 8);
        push_frame(160, 32, 4, 8);
        push_frame(160, 32, 4, 8);
        push_frame(-1, 32, 4, 8);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) expect_next("first_sync", 6'b110010);
            else expect_next("lead_in", 6'b000000);
        end
        @(negedge clk);
        wait_fs("f2_start");
        wait_fs("f3_start");
        repeat (20) @(posedge clk);
        #1;
        ht = 20;
        wait_fs("f4_start");
        wait_fs("f5_start");
        repeat (20) @(posedge clk);
        #1;
        ht = 16;
        wait_fs("f6_start");
        repeat (49) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (74) @(posedge clk);
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            expect_next("idle_drain", 6'b000000);
        end
        flush_req++;
        push_frame(128, 32, 4, 8);
        en = 1'b1;
        wait_fs("f7a_start");
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        abort_req++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_next("reset_midframe", 6'b000000);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) expect_next("restart_sync", 6'b110010);
            else expect_next("restart_lead", 6'b000000);
        end
        @(negedge clk);
        repeat (20) @(posedge clk);
        #1;
        ht = 2200; vt = 1125; hsn = 44; vsn = 5;
        sp = 192; ep = 2112; sh = 41; eh = 1121;
        wait_fs("f8_start");
        for (int i = 1; i <= 11044; i++) begin
            @(posedge clk);
            #1;
            case (i)
                43:      expect_next("hd_hs_last", 6'b110000);
                44:      expect_next("hd_hs_end", 6'b010000);
                2199:    expect_next("hd_line_end", 6'b010000);
                2200:    expect_next("hd_line1", 6'b110000);
                10999:   expect_next("hd_vs_last", 6'b010000);
                11000:   expect_next("hd_vs_end", 6'b100000);
                11044:   expect_next("hd_line5_hs", 6'b000000);
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        abort_req++;
        done_req = 1;
    end

endmodule
